dma_controller: RTL and testbench
=================================

# dma_controller

Block-copy engine between external memory and local block RAM. It splits a word-count transfer into INCR bursts and drives the DMA-side read/write request and data channels of the memory arbiter. The arbiter forwards these to the AXI adapter whenever the accelerator is not busy. The local side is a single synchronous-read BRAM port; software programs the block through the CSR inputs.

## Interface
- AXI_AWIDTH, 32: external byte-address width
- AXI_DWIDTH, 32: data width; one beat is one word
- LOCAL_AWIDTH, 14: local BRAM word-address width
- MAX_BURST, 16: maximum beats per burst; a power of two, at most 256

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- dma_start  in  1  start pulse; sampled only in IDLE
- dma_dir  in  1  0: external→local (load); 1: local→external (store)
- dma_src_addr  in  AXI_AWIDTH  source byte address; word-aligned
- dma_dst_addr  in  AXI_AWIDTH  destination byte address; word-aligned
- dma_len  in  32  transfer length in words
- dma_idle  out  1  high in IDLE
- dma_done  out  1  sticky; set on completion, cleared by an accepted start
- dma_cycles  out  32  busy-cycle count (see Configuration)
- mem_en  out  1  BRAM enable
- mem_we  out  4  BRAM byte write enables
- mem_addr  out  LOCAL_AWIDTH  BRAM word address
- mem_wdata  out  AXI_DWIDTH  BRAM write data
- mem_rdata  in  AXI_DWIDTH  BRAM read data; valid one cycle after mem_en
- dma_read_request_valid / _ready, dma_read_addr, dma_read_len, dma_read_size, dma_read_burst: read request channel; out/in/out/out/out/out
- dma_read_data  in  AXI_DWIDTH; dma_read_data_valid  in  1; dma_read_data_ready  out  1
- dma_write_request_valid / _ready, dma_write_addr, dma_write_len, dma_write_size, dma_write_burst: write request channel; same directions as the read request channel
- dma_write_data  out  AXI_DWIDTH; dma_write_data_valid  out  1; dma_write_data_ready  in  1

## Operation
- States: IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA.
- The local address is dst>>2 for a load and src>>2 for a store, truncated to LOCAL_AWIDTH.
- **Start in IDLE.** Latch addresses, set remaining = dma_len, clear dma_done.
  - dma_len==0: set dma_done next cycle, stay in IDLE, issue no request.
  - Otherwise go to RD_REQ (dir=0) or WR_REQ (dir=1).
- **Burst length.** beats = min(remaining, MAX_BURST). Request fields:
  - len = beats-1
  - size = 3'b010
  - burst = 2'b01 (INCR)
  - addr = current external byte address
- No 4 KB-boundary split is performed; software keeps bursts within one 4 KB page.
- **Load path.**
  - RD_REQ: hold valid until ready, then go to RD_DATA.
  - RD_DATA: dma_read_data_ready=1. Each valid beat writes the BRAM in the same cycle (mem_en=1, mem_we=4'hF) and increments the local address.
  - After the last beat: remaining -= beats, external address += beats*4. Go to RD_REQ if remaining>0, else IDLE with dma_done=1.
- **Store path.**
  - A 2-entry prefetch FIFO is filled from the BRAM. A read is issued only when occupancy plus in-flight reads is below 2 and the current burst still has unissued beats.
  - Prefetch starts on entry to WR_REQ, overlapping the request handshake.
  - WR_DATA: dma_write_data_valid = FIFO not empty; pop on handshake.
  - Completion is the final data handshake; there is no write-response channel. Burst sequencing is as on the load path.
- dma_start outside IDLE is ignored.
- Reset mid-transfer:
  - Return to IDLE, flush the FIFO, deassert all valids.
  - The in-flight external transaction is not cancelled; the adapter shares rst.

## Timing
- Reset values: all valids, mem_en, mem_we, dma_done and dma_cycles are 0; dma_idle=1; addresses, len and data are 0; size=3'b010; burst=2'b01.
- dma_start accepted at cycle N → request valid at N+1.
- Request fields are stable while valid is high and ready is low.
- Load throughput: 1 beat/cycle.
- Store throughput: 1 beat/cycle after a 2-cycle fill; first data valid no earlier than 2 cycles after entering WR_REQ.
- Store stalls: data is held stable while ready is low, and prefetch stops when the FIFO is full.
- Next burst request: one cycle after the final beat of the previous burst.
- Completion: dma_done and dma_idle rise the cycle after the final beat handshake.

## Configuration
- DMA_CYCLE_COUNT_EN defined:
  - dma_cycles clears on an accepted start.
  - It increments every cycle the block is not in IDLE and saturates at 32'hFFFFFFFF.
- DMA_CYCLE_COUNT_EN undefined: dma_cycles is tied to 0 and the counter logic is absent.

## Structure
- Shared package dma_defs holds:
  - state encodings
  - AXI_SIZE_WORD = 3'b010
  - AXI_BURST_INCR = 2'b01
- Sub-module dma_prefetch_fifo: 2-entry, width AXI_DWIDTH, push/pop/full/empty/count, synchronous flush on rst.

## Test plan
- **Single load.** dir=0, src=0x1000, dst=0x0, len=4 → one read request (addr 0x1000, len 3, size 2, burst 1). BRAM words 0–3 receive data 0xA0–0xA3. dma_done set one cycle after beat 4.
- **Burst split.** dir=0, len=20, MAX_BURST=16 → requests (0x1000, len 15) then (0x1040, len 3). 20 BRAM writes with contiguous addresses.
- **Store with backpressure.** dir=1, src=0x40, dst=0x2000, len=8, BRAM preloaded with 0..7, dma_write_data_ready toggling every cycle → write request (0x2000, len 7). Data beats 0..7 in order, no drops or duplicates, data stable during stalls.
- **Zero length.** dma_len=0 with start → no request valid ever asserted; dma_done=1 the next cycle; dma_idle stays 1.
- **Reset mid-burst.** rst asserted during RD_DATA beat 2 → next cycle all valids are 0, dma_idle=1, dma_done=0. A following start with len=1 completes normally.
- **Ignored start and cycle count.** Start pulsed while busy → ignored and parameters unchanged. With DMA_CYCLE_COUNT_EN, a len=4 load with an immediate ready reports dma_cycles=6.

Source files
------------

// File: rtl/dma_defs.sv
// Shared definitions for the DMA block-copy engine: FSM state encodings and
// the fixed AXI request field encodings used on both request channels.
package dma_defs;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_REQ  = 3'd1,
      ST_RD_DATA = 3'd2,
      ST_WR_REQ  = 3'd3,
      ST_WR_DATA = 3'd4
   } dma_state_e;

   localparam logic [2:0]  AXI_SIZE_WORD  = 3'b010;
   localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
   localparam int unsigned AXI_LEN_W      = 8;

endpackage

// File: rtl/dma_prefetch_fifo.sv
// Two-entry prefetch FIFO between the BRAM read port and the DMA write-data
// channel; synchronous flush on rst.
module dma_prefetch_fifo #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [1:0]       count
);

   logic [1:0][WIDTH-1:0] mem_q, mem_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic [1:0]            count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + 2'(push) - 2'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign full     = (count_q == 2'd2);
   assign empty    = (count_q == 2'd0);
   assign count    = count_q;

endmodule

// File: rtl/dma_controller.sv
// Block-copy engine between external memory (INCR bursts) and local BRAM.
// Optional busy-cycle counter enabled by defining DMA_CYCLE_COUNT_EN.
module dma_controller
   import dma_defs::*;
#(
   parameter int unsigned AXI_AWIDTH   = 32,
   parameter int unsigned AXI_DWIDTH   = 32,
   parameter int unsigned LOCAL_AWIDTH = 14,
   parameter int unsigned MAX_BURST    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    dma_start,
   input  logic                    dma_dir,
   input  logic [AXI_AWIDTH-1:0]   dma_src_addr,
   input  logic [AXI_AWIDTH-1:0]   dma_dst_addr,
   input  logic [31:0]             dma_len,
   output logic                    dma_idle,
   output logic                    dma_done,
   output logic [31:0]             dma_cycles,
   output logic                    mem_en,
   output logic [3:0]              mem_we,
   output logic [LOCAL_AWIDTH-1:0] mem_addr,
   output logic [AXI_DWIDTH-1:0]   mem_wdata,
   input  logic [AXI_DWIDTH-1:0]   mem_rdata,
   output logic                    dma_read_request_valid,
   input  logic                    dma_read_request_ready,
   output logic [AXI_AWIDTH-1:0]   dma_read_addr,
   output logic [AXI_LEN_W-1:0]    dma_read_len,
   output logic [2:0]              dma_read_size,
   output logic [1:0]              dma_read_burst,
   input  logic [AXI_DWIDTH-1:0]   dma_read_data,
   input  logic                    dma_read_data_valid,
   output logic                    dma_read_data_ready,
   output logic                    dma_write_request_valid,
   input  logic                    dma_write_request_ready,
   output logic [AXI_AWIDTH-1:0]   dma_write_addr,
   output logic [AXI_LEN_W-1:0]    dma_write_len,
   output logic [2:0]              dma_write_size,
   output logic [1:0]              dma_write_burst,
   output logic [AXI_DWIDTH-1:0]   dma_write_data,
   output logic                    dma_write_data_valid,
   input  logic                    dma_write_data_ready
);

   localparam int unsigned BEAT_W = 9;

   dma_state_e              state_q, state_d;
   logic [AXI_AWIDTH-1:0]   ext_addr_q, ext_addr_d;
   logic [LOCAL_AWIDTH-1:0] loc_addr_q, loc_addr_d;
   logic [31:0]             remaining_q, remaining_d;
   logic [AXI_LEN_W-1:0]    req_len_q, req_len_d;
   logic [BEAT_W-1:0]       beats_left_q, beats_left_d;
   logic [BEAT_W-1:0]       unissued_q, unissued_d;
   logic                    inflight_q, inflight_d;
   logic                    done_q, done_d;
   logic [BEAT_W-1:0]       cur_beats;
   logic                    last_beat;
   logic [2:0]              prefetch_occ;
   logic                    fifo_pop, fifo_full, fifo_empty;
   logic [1:0]              fifo_count;
   logic [AXI_DWIDTH-1:0]   fifo_data;

   function automatic logic [BEAT_W-1:0] burst_beats(input logic [31:0] rem);
      return (rem < 32'(MAX_BURST)) ? BEAT_W'(rem) : BEAT_W'(MAX_BURST);
   endfunction

   assign cur_beats = BEAT_W'(req_len_q) + BEAT_W'(1);

   dma_prefetch_fifo #(.WIDTH(AXI_DWIDTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_q),
      .push_data (mem_rdata),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      state_d      = state_q;
      ext_addr_d   = ext_addr_q;
      loc_addr_d   = loc_addr_q;
      remaining_d  = remaining_q;
      req_len_d    = req_len_q;
      beats_left_d = beats_left_q;
      unissued_d   = unissued_q;
      inflight_d   = 1'b0;
      done_d       = done_q;
      last_beat    = 1'b0;
      fifo_pop     = 1'b0;
      prefetch_occ = 3'd0;
      mem_en       = 1'b0;
      mem_we       = 4'h0;
      mem_wdata    = '0;

      case (state_q)
         ST_IDLE: begin
            if (dma_start) begin
               done_d      = (dma_len == 32'd0);
               remaining_d = dma_len;
               ext_addr_d  = dma_dir ? dma_dst_addr : dma_src_addr;
               loc_addr_d  = LOCAL_AWIDTH'((dma_dir ? dma_src_addr : dma_dst_addr) >> 2);
               if (dma_len != 32'd0) begin
                  req_len_d    = AXI_LEN_W'(burst_beats(dma_len) - BEAT_W'(1));
                  beats_left_d = burst_beats(dma_len);
                  unissued_d   = burst_beats(dma_len);
                  state_d      = dma_dir ? ST_WR_REQ : ST_RD_REQ;
               end
            end
         end
         ST_RD_REQ: begin
            if (dma_read_request_ready) state_d = ST_RD_DATA;
         end
         ST_RD_DATA: begin
            if (dma_read_data_valid) begin
               mem_en       = 1'b1;
               mem_we       = 4'hF;
               mem_wdata    = dma_read_data;
               loc_addr_d   = loc_addr_q + LOCAL_AWIDTH'(1);
               beats_left_d = beats_left_q - BEAT_W'(1);
               last_beat    = (beats_left_q == BEAT_W'(1));
            end
         end
         ST_WR_REQ: begin
            if (dma_write_request_ready) state_d = ST_WR_DATA;
         end
         ST_WR_DATA: begin
            if (dma_write_data_ready && !fifo_empty) begin
               fifo_pop     = 1'b1;
               beats_left_d = beats_left_q - BEAT_W'(1);
               last_beat    = (beats_left_q == BEAT_W'(1));
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // BRAM prefetch counts the slot freed by a same-cycle pop to sustain 1 beat/cycle
      prefetch_occ = 3'(fifo_count) + 3'(inflight_q) - 3'(fifo_pop);
      if ((state_q == ST_WR_REQ || state_q == ST_WR_DATA) && (unissued_q != '0) &&
          (prefetch_occ < 3'd2) && (!fifo_full || fifo_pop)) begin
         mem_en     = 1'b1;
         loc_addr_d = loc_addr_q + LOCAL_AWIDTH'(1);
         unissued_d = unissued_q - BEAT_W'(1);
         inflight_d = 1'b1;
      end

      if (last_beat) begin
         remaining_d = remaining_q - 32'(cur_beats);
         ext_addr_d  = ext_addr_q + AXI_AWIDTH'({cur_beats, 2'b00});
         if (remaining_d == 32'd0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end else begin
            state_d      = (state_q == ST_RD_DATA) ? ST_RD_REQ : ST_WR_REQ;
            req_len_d    = AXI_LEN_W'(burst_beats(remaining_d) - BEAT_W'(1));
            beats_left_d = burst_beats(remaining_d);
            unissued_d   = burst_beats(remaining_d);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         ext_addr_q   <= '0;
         loc_addr_q   <= '0;
         remaining_q  <= '0;
         req_len_q    <= '0;
         beats_left_q <= '0;
         unissued_q   <= '0;
         inflight_q   <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ext_addr_q   <= ext_addr_d;
         loc_addr_q   <= loc_addr_d;
         remaining_q  <= remaining_d;
         req_len_q    <= req_len_d;
         beats_left_q <= beats_left_d;
         unissued_q   <= unissued_d;
         inflight_q   <= inflight_d;
         done_q       <= done_d;
      end
   end

`ifdef DMA_CYCLE_COUNT_EN
   logic [31:0] cycles_q, cycles_d;

   // Busy-cycle counter: restarts on an accepted start, saturates at all-ones
   always_comb begin
      cycles_d = cycles_q;
      if (state_q == ST_IDLE) begin
         if (dma_start) cycles_d = 32'd0;
      end else if (cycles_q != 32'hFFFF_FFFF) begin
         cycles_d = cycles_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cycles_q <= 32'd0;
      else     cycles_q <= cycles_d;
   end

   assign dma_cycles = cycles_q;
`else
   assign dma_cycles = 32'd0;
`endif

   assign dma_idle                = (state_q == ST_IDLE);
   assign dma_done                = done_q;
   assign mem_addr                = loc_addr_q;
   assign dma_read_request_valid  = (state_q == ST_RD_REQ);
   assign dma_read_addr           = ext_addr_q;
   assign dma_read_len            = req_len_q;
   assign dma_read_size           = AXI_SIZE_WORD;
   assign dma_read_burst          = AXI_BURST_INCR;
   assign dma_read_data_ready     = (state_q == ST_RD_DATA);
   assign dma_write_request_valid = (state_q == ST_WR_REQ);
   assign dma_write_addr          = ext_addr_q;
   assign dma_write_len           = req_len_q;
   assign dma_write_size          = AXI_SIZE_WORD;
   assign dma_write_burst         = AXI_BURST_INCR;
   assign dma_write_data          = fifo_data;
   assign dma_write_data_valid    = (state_q == ST_WR_DATA) && !fifo_empty;

endmodule

// File: tb/tb_dma_controller.sv
// Directed scoreboard bench for dma_controller: bus responders and a BRAM model
// are serviced once per clock from the stimulus thread.
module tb_dma_controller;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
   } req_t;

   typedef struct {
      logic [13:0] addr;
      logic [31:0] data;
   } bram_t;

   logic        clk;
   logic        rst;
   logic        dma_start;
   logic        dma_dir;
   logic [31:0] dma_src_addr;
   logic [31:0] dma_dst_addr;
   logic [31:0] dma_len;
   logic        dma_idle;
   logic        dma_done;
   logic [31:0] dma_cycles;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [13:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        dma_read_request_valid;
   logic        dma_read_request_ready;
   logic [31:0] dma_read_addr;
   logic [7:0]  dma_read_len;
   logic [2:0]  dma_read_size;
   logic [1:0]  dma_read_burst;
   logic [31:0] dma_read_data;
   logic        dma_read_data_valid;
   logic        dma_read_data_ready;
   logic        dma_write_request_valid;
   logic        dma_write_request_ready;
   logic [31:0] dma_write_addr;
   logic [7:0]  dma_write_len;
   logic [2:0]  dma_write_size;
   logic [1:0]  dma_write_burst;
   logic [31:0] dma_write_data;
   logic        dma_write_data_valid;
   logic        dma_write_data_ready;

   dma_controller dut (
      .clk                     (clk),
      .rst                     (rst),
      .dma_start               (dma_start),
      .dma_dir                 (dma_dir),
      .dma_src_addr            (dma_src_addr),
      .dma_dst_addr            (dma_dst_addr),
      .dma_len                 (dma_len),
      .dma_idle                (dma_idle),
      .dma_done                (dma_done),
      .dma_cycles              (dma_cycles),
      .mem_en                  (mem_en),
      .mem_we                  (mem_we),
      .mem_addr                (mem_addr),
      .mem_wdata               (mem_wdata),
      .mem_rdata               (mem_rdata),
      .dma_read_request_valid  (dma_read_request_valid),
      .dma_read_request_ready  (dma_read_request_ready),
      .dma_read_addr           (dma_read_addr),
      .dma_read_len            (dma_read_len),
      .dma_read_size           (dma_read_size),
      .dma_read_burst          (dma_read_burst),
      .dma_read_data           (dma_read_data),
      .dma_read_data_valid     (dma_read_data_valid),
      .dma_read_data_ready     (dma_read_data_ready),
      .dma_write_request_valid (dma_write_request_valid),
      .dma_write_request_ready (dma_write_request_ready),
      .dma_write_addr          (dma_write_addr),
      .dma_write_len           (dma_write_len),
      .dma_write_size          (dma_write_size),
      .dma_write_burst         (dma_write_burst),
      .dma_write_data          (dma_write_data),
      .dma_write_data_valid    (dma_write_data_valid),
      .dma_write_data_ready    (dma_write_data_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          last_beat_cyc = 0;
   int          rd_beats = 0;
   int          rd_delay = 0;
   logic [31:0] rd_data = '0;
   logic        wr_toggle = 1'b0;
   logic        hold_valid = 1'b0;
   logic [31:0] hold_data = '0;
   logic        rd_pend = 1'b0;
   logic [31:0] rd_next = '0;
   logic [31:0] bram [64];

   req_t        exp_rreq[$];
   req_t        exp_wreq[$];
   bram_t       exp_bram[$];
   logic [31:0] exp_wdata[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive responder inputs, settle, score DUT activity, advance.
   task automatic cycle();
      req_t  r;
      bram_t b;
      cyc++;
      dma_read_request_ready = 1'b1;
      if (rd_delay != 0) begin
         dma_read_data_valid = 1'b0;
         rd_delay--;
      end else begin
         dma_read_data_valid = (rd_beats != 0);
      end
      dma_read_data           = rd_data;
      dma_write_request_ready = 1'b1;
      dma_write_data_ready    = wr_toggle ? cyc[0] : 1'b1;
      #1;
      if (dma_read_request_valid === 1'b1 && dma_read_request_ready) begin
         chk("rreq_expected", 64'(exp_rreq.size() != 0), 64'(1));
         if (exp_rreq.size() != 0) begin
            r = exp_rreq.pop_front();
            chk("rreq_addr", 64'(dma_read_addr), 64'(r.addr));
            chk("rreq_len", 64'(dma_read_len), 64'(r.len));
         end
         chk("rreq_size", 64'(dma_read_size), 64'(3'b010));
         chk("rreq_burst", 64'(dma_read_burst), 64'(2'b01));
         rd_beats = int'(dma_read_len) + 1;
         rd_delay = 1;
      end
      if (dma_read_data_valid && dma_read_data_ready === 1'b1) begin
         rd_beats--;
         rd_data++;
      end
      if (mem_en === 1'b1 && mem_we !== 4'h0) begin
         chk("bram_expected", 64'(exp_bram.size() != 0), 64'(1));
         chk("bram_we", 64'(mem_we), 64'(4'hF));
         if (exp_bram.size() != 0) begin
            b = exp_bram.pop_front();
            chk("bram_addr", 64'(mem_addr), 64'(b.addr));
            chk("bram_data", 64'(mem_wdata), 64'(b.data));
            if (exp_bram.size() == 0) last_beat_cyc = cyc;
         end
      end
      if (mem_en === 1'b1 && mem_we === 4'h0) begin
         rd_next = bram[mem_addr[5:0]];
         rd_pend = 1'b1;
      end
      if (dma_write_request_valid === 1'b1 && dma_write_request_ready) begin
         chk("wreq_expected", 64'(exp_wreq.size() != 0), 64'(1));
         if (exp_wreq.size() != 0) begin
            r = exp_wreq.pop_front();
            chk("wreq_addr", 64'(dma_write_addr), 64'(r.addr));
            chk("wreq_len", 64'(dma_write_len), 64'(r.len));
         end
         chk("wreq_size", 64'(dma_write_size), 64'(3'b010));
         chk("wreq_burst", 64'(dma_write_burst), 64'(2'b01));
      end
      if (dma_write_data_valid === 1'b1) begin
         if (hold_valid) chk("wdata_stable", 64'(dma_write_data), 64'(hold_data));
         if (dma_write_data_ready) begin
            hold_valid = 1'b0;
            chk("wdata_expected", 64'(exp_wdata.size() != 0), 64'(1));
            if (exp_wdata.size() != 0) begin
               chk("wdata", 64'(dma_write_data), 64'(exp_wdata.pop_front()));
               if (exp_wdata.size() == 0) last_beat_cyc = cyc;
            end
         end else begin
            hold_valid = 1'b1;
            hold_data  = dma_write_data;
         end
      end
      @(posedge clk);
      #1;
      if (rd_pend) begin
         mem_rdata = rd_next;
         rd_pend   = 1'b0;
      end
   endtask

   task automatic start(input logic dir, input logic [31:0] src, input logic [31:0] dst,
                        input logic [31:0] len);
      dma_start    = 1'b1;
      dma_dir      = dir;
      dma_src_addr = src;
      dma_dst_addr = dst;
      dma_len      = len;
      cycle();
      dma_start    = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (dma_done !== 1'b1 && n < budget) begin
         cycle();
         n++;
      end
      chk({tag, "_done"}, 64'(dma_done), 64'(1));
      chk({tag, "_idle"}, 64'(dma_idle), 64'(1));
      chk({tag, "_done_latency"}, 64'(cyc + 1 - last_beat_cyc), 64'(1));
   endtask

   task automatic check_drained(input string tag);
      chk({tag, "_rreq_left"}, 64'(exp_rreq.size()), 64'(0));
      chk({tag, "_wreq_left"}, 64'(exp_wreq.size()), 64'(0));
      chk({tag, "_bram_left"}, 64'(exp_bram.size()), 64'(0));
      chk({tag, "_wdata_left"}, 64'(exp_wdata.size()), 64'(0));
   endtask

   initial begin
      rst                     = 1'b1;
      dma_start               = 1'b0;
      dma_dir                 = 1'b0;
      dma_src_addr            = '0;
      dma_dst_addr            = '0;
      dma_len                 = '0;
      mem_rdata               = '0;
      dma_read_request_ready  = 1'b0;
      dma_read_data           = '0;
      dma_read_data_valid     = 1'b0;
      dma_write_request_ready = 1'b0;
      dma_write_data_ready    = 1'b0;
      for (int i = 0; i < 64; i++) begin
         bram[i] = (i >= 16 && i < 24) ? 32'(i - 16) : (32'hDEAD_0000 | 32'(i));
      end

      // Reset state
      repeat (2) cycle();
      chk("rst_idle", 64'(dma_idle), 64'(1));
      chk("rst_done", 64'(dma_done), 64'(0));
      chk("rst_cycles", 64'(dma_cycles), 64'(0));
      chk("rst_rreq_valid", 64'(dma_read_request_valid), 64'(0));
      chk("rst_wreq_valid", 64'(dma_write_request_valid), 64'(0));
      chk("rst_wdata_valid", 64'(dma_write_data_valid), 64'(0));
      chk("rst_mem_en", 64'(mem_en), 64'(0));
      chk("rst_mem_we", 64'(mem_we), 64'(0));
      chk("rst_rd_addr", 64'(dma_read_addr), 64'(0));
      chk("rst_rd_len", 64'(dma_read_len), 64'(0));
      chk("rst_rd_size", 64'(dma_read_size), 64'(3'b010));
      chk("rst_rd_burst", 64'(dma_read_burst), 64'(2'b01));
      chk("rst_wr_data", 64'(dma_write_data), 64'(0));
      rst = 1'b0;
      cycle();

      // Single load
      exp_rreq.push_back('{addr: 32'h1000, len: 8'd3});
      for (int i = 0; i < 4; i++) exp_bram.push_back('{addr: 14'(i), data: 32'hA0 + 32'(i)});
      rd_data = 32'hA0;
      start(1'b0, 32'h1000, 32'h0, 32'd4);
      chk("load_rreq_valid_n1", 64'(dma_read_request_valid), 64'(1));
      wait_done("load", 100);
      check_drained("load");

      // Burst split
      exp_rreq.push_back('{addr: 32'h1000, len: 8'd15});
      exp_rreq.push_back('{addr: 32'h1040, len: 8'd3});
      for (int i = 0; i < 20; i++) exp_bram.push_back('{addr: 14'(i), data: 32'hB00 + 32'(i)});
      rd_data = 32'hB00;
      start(1'b0, 32'h1000, 32'h0, 32'd20);
      wait_done("split", 200);
      check_drained("split");

      // Store with toggling write-data backpressure
      wr_toggle = 1'b1;
      exp_wreq.push_back('{addr: 32'h2000, len: 8'd7});
      for (int i = 0; i < 8; i++) exp_wdata.push_back(32'(i));
      start(1'b1, 32'h40, 32'h2000, 32'd8);
      wait_done("store", 200);
      check_drained("store");
      wr_toggle = 1'b0;

      // Zero length
      start(1'b0, 32'h3000, 32'h10, 32'd0);
      chk("zero_done", 64'(dma_done), 64'(1));
      for (int i = 0; i < 4; i++) begin
         chk("zero_idle", 64'(dma_idle), 64'(1));
         cycle();
      end
      check_drained("zero");

      // Reset during the second beat of a load burst
      exp_rreq.push_back('{addr: 32'h3000, len: 8'd3});
      for (int i = 0; i < 4; i++) exp_bram.push_back('{addr: 14'h40 + 14'(i), data: 32'hC0 + 32'(i)});
      rd_data = 32'hC0;
      start(1'b0, 32'h3000, 32'h100, 32'd4);
      for (int n = 0; n < 20 && exp_bram.size() > 3; n++) cycle();
      chk("rst_mid_beat1", 64'(exp_bram.size()), 64'(3));
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      exp_bram.delete();
      rd_beats = 0;
      rd_delay = 0;
      dma_read_data_valid = 1'b0;
      chk("rst_mid_rreq_valid", 64'(dma_read_request_valid), 64'(0));
      chk("rst_mid_wreq_valid", 64'(dma_write_request_valid), 64'(0));
      chk("rst_mid_wdata_valid", 64'(dma_write_data_valid), 64'(0));
      chk("rst_mid_idle", 64'(dma_idle), 64'(1));
      chk("rst_mid_done", 64'(dma_done), 64'(0));
      exp_rreq.push_back('{addr: 32'h500, len: 8'd0});
      exp_bram.push_back('{addr: 14'h8, data: 32'hD0});
      rd_data = 32'hD0;
      start(1'b0, 32'h500, 32'h20, 32'd1);
      wait_done("after_rst", 100);
      check_drained("after_rst");

      // Start while busy is ignored; busy-cycle count for a len=4 load
      exp_rreq.push_back('{addr: 32'h1000, len: 8'd3});
      for (int i = 0; i < 4; i++) exp_bram.push_back('{addr: 14'h80 + 14'(i), data: 32'hE0 + 32'(i)});
      rd_data = 32'hE0;
      start(1'b0, 32'h1000, 32'h200, 32'd4);
      repeat (2) cycle();
      start(1'b1, 32'h7000, 32'h40, 32'd9);
      wait_done("ignored", 100);
`ifdef DMA_CYCLE_COUNT_EN
      chk("cycles_len4", 64'(dma_cycles), 64'(6));
`else
      chk("cycles_len4", 64'(dma_cycles), 64'(0));
`endif
      repeat (3) cycle();
      check_drained("ignored");
      chk("ignored_idle", 64'(dma_idle), 64'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
